fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction-fetch stage of the 5-stage pipeline. It is the producer of decode's inputs: it owns the PC, drives the stallable instruction memory, and presents instr/valid/align_err_i to the IF/ID boundary. It also generates the three-cycle flush sequence flush, flush_again and flush_final after a control redirect.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset.
NOP_INSTR, 16'h0800, instruction word driven to decode whenever valid=0.

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
stall_i  input  1  hazard stall from decode; hold the IF/ID output
redirect  input  1  branch/jump resolved taken; one-cycle pulse
redirect_pc  input  16  target PC, sampled when redirect=1
halt_i  input  1  HALT decoded; stop fetching
imem_rd  output  1  memory read request, held high as a level
imem_addr  output  16  memory address; stable while a request is open
imem_data  input  16  read data, valid when imem_done=1
imem_done  input  1  request complete this cycle
imem_stall  input  1  memory busy (status only; no action required)
instr  output  16  IF/ID instruction
pc_plus2  output  16  IF/ID PC+2 of instr
valid  output  1  instr is a real fetched instruction
align_err_i  output  1  odd PC fetch attempted
flush  output  1  flush stage 1
flush_again  output  1  flush stage 2
flush_final  output  1  flush stage 3

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - pc=RESET_PC, state=RUN.
  - instr=NOP_INSTR, pc_plus2=0, valid=0, align_err_i=0.
  - All flush bits 0, skid buffer empty.
  - imem_rd=0 during the reset cycle.
  - Reset mid-request abandons the request without draining.
- States: RUN, DRAIN, ALIGN, HALT.
- RUN:
  - imem_rd=1 and imem_addr=pc while the skid buffer is empty and pc[0]=0.
  - On imem_done, pc<=pc+2 (16-bit wrap: 16'hFFFE+2=16'h0000).
  - If stall_i=0, the data goes to the outputs: instr=imem_data, pc_plus2=pc+2, valid=1 from the next cycle.
  - If stall_i=1, the data is captured in the one-entry skid buffer, and imem_rd=0 while the buffer is full.
  - If there is no done and stall_i=0, outputs become NOP_INSTR with valid=0 (bubble).
  - If stall_i=1, the outputs hold.
- Skid buffer:
  - On the first cycle with stall_i=0, the buffer moves to the outputs and the buffer empties.
  - A new request issues on the same cycle the buffer empties.
  - Latency: done to output is 1 cycle; buffered data reaches the output 1 cycle after stall_i falls.
- redirect=1 (priority over stall_i, done and halt_i):
  - Skid buffer cleared, outputs to NOP_INSTR/valid=0, align_err_i=0.
  - If no request is open, or done arrives in this same cycle: pc<=redirect_pc, stay RUN, and any done data is discarded.
  - If a request is open without done: save redirect_pc into pending_pc and go to DRAIN.
- DRAIN:
  - Hold imem_rd=1 with the old address until imem_done.
  - Discard that data, load pc<=pending_pc, return to RUN.
  - Issue the next request the cycle after.
  - A second redirect during DRAIN overwrites pending_pc.
- Flush sequence:
  - redirect at cycle N gives flush=1 at N+1, flush_again=1 at N+2, flush_final=1 at N+3; each is a one-cycle pulse.
  - A redirect during the sequence restarts it.
  - Overlapping sequences OR together.
- Alignment: pc[0]=1 in RUN means no request is issued; go to ALIGN.
  - ALIGN: align_err_i=1 and valid=0, held until redirect or rst.
- Halt: halt_i=1 with no redirect.
  - Finish any open request; its data is delivered normally.
  - Then enter HALT: imem_rd=0, outputs go to NOP_INSTR/valid=0 once any buffered data is consumed.
  - HALT exits only on rst.
- Invariant: imem_addr never changes while imem_rd=1 and imem_done=0.

Test Plan:
- Reset release, 1-cycle memory, words at 0x0000/0x0002 = 0xC001/0xC002 -> imem_addr 0,2,4 on consecutive cycles; instr 0xC001 with valid=1 and pc_plus2=0x0002, then 0xC002.
- stall_i high for 3 cycles while done returns 0xD0A0 -> output holds prior instr, buffer holds 0xD0A0, imem_rd=0 during the stall; 0xD0A0 appears one cycle after stall_i falls.
- 4-cycle memory; redirect to 0x0100 on cycle 2 of the request -> DRAIN holds the old address until done; old data is discarded; next imem_addr=0x0100; flush, flush_again, flush_final pulse on the 3 cycles after redirect.
- redirect_pc=0x0011 -> no request issued; align_err_i=1, valid=0 persistently; a later redirect to 0x0020 clears it and fetches 0x0020.
- halt_i asserted with a request open -> that instr is delivered, then imem_rd=0 forever; rst returns pc to RESET_PC.
- pc=0xFFFE, done -> next imem_addr=0x0000 and pc_plus2=0x0000.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Bundle of the fetch stage's control inputs, instruction-memory port and
// IF/ID outputs, plus a debug view of the fetch FSM state.
//
// Memory handshake: imem_rd is a level request. Once raised, it stays high
// and imem_addr stays constant until a cycle in which imem_done=1. That cycle
// completes the transfer, and imem_data is valid only in that cycle.
// IF/ID handshake: decode takes instr/pc_plus2 on every edge where valid=1
// and stall_i=0. When stall_i=1 the fetch stage holds its outputs.
interface fetch_unit_if;
  logic        stall_i;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        halt_i;
  logic        imem_rd;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic        imem_done;
  logic        imem_stall;
  logic [15:0] instr;
  logic [15:0] pc_plus2;
  logic        valid;
  logic        align_err_i;
  logic        flush;
  logic        flush_again;
  logic        flush_final;
  logic [1:0]  dbg_state;

  modport master (
    input  stall_i, redirect, redirect_pc, halt_i, imem_data, imem_done, imem_stall,
    output imem_rd, imem_addr, instr, pc_plus2, valid, align_err_i,
           flush, flush_again, flush_final, dbg_state
  );

  modport slave (
    output stall_i, redirect, redirect_pc, halt_i, imem_data, imem_done, imem_stall,
    input  imem_rd, imem_addr, instr, pc_plus2, valid, align_err_i,
           flush, flush_again, flush_final, dbg_state
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the stallable instruction
// memory, buffers one word while decode stalls, and emits the three-stage
// flush pulse train after a redirect.
module fetch_unit #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);
  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, ALIGN = 2'd2, HALT = 2'd3} state_t;

  state_t      state;
  logic [15:0] pc;
  logic [15:0] pc_inc;
  logic [15:0] pending_pc;
  logic [15:0] skid_instr;
  logic [15:0] skid_pc2;
  logic        skid_full;
  logic        halt_pend;
  logic [15:0] instr_q;
  logic [15:0] pc2_q;
  logic        valid_q;
  logic        align_q;
  logic        flush_q;
  logic        flush_again_q;
  logic        flush_final_q;
  logic        rd;
  logic        accept;
  logic        redirect_take;
  logic        deliver_en;
  logic        unused_imem_stall;

  assign pc_inc            = pc + 16'd2;
  assign unused_imem_stall = bus.imem_stall;

  // Request level: RUN fetches while the skid is free and pc is even; DRAIN
  // keeps the abandoned request alive so the address never moves mid-request.
  always_comb begin
    rd = 1'b0;
    if (!rst) begin
      case (state)
        RUN:     rd = !skid_full && !pc[0];
        DRAIN:   rd = 1'b1;
        default: rd = 1'b0;
      endcase
    end
  end

  assign accept        = rd && bus.imem_done;
  // HALT is terminal, so a redirect there has no effect.
  assign redirect_take = bus.redirect && (state != HALT);
  // Normal output/skid handling applies in RUN (even pc) and while HALT drains.
  assign deliver_en    = (state == RUN && !pc[0]) || (state == HALT);

  assign bus.imem_rd     = rd;
  assign bus.imem_addr   = pc;
  assign bus.instr       = instr_q;
  assign bus.pc_plus2    = pc2_q;
  assign bus.valid       = valid_q;
  assign bus.align_err_i = align_q;
  assign bus.flush       = flush_q;
  assign bus.flush_again = flush_again_q;
  assign bus.flush_final = flush_final_q;
  assign bus.dbg_state   = state;

  // Fetch FSM, PC, skid buffer, IF/ID outputs and flush shift chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= RUN;
      pc            <= RESET_PC;
      pending_pc    <= RESET_PC;
      skid_instr    <= NOP_INSTR;
      skid_pc2      <= 16'h0000;
      skid_full     <= 1'b0;
      halt_pend     <= 1'b0;
      instr_q       <= NOP_INSTR;
      pc2_q         <= 16'h0000;
      valid_q       <= 1'b0;
      align_q       <= 1'b0;
      flush_q       <= 1'b0;
      flush_again_q <= 1'b0;
      flush_final_q <= 1'b0;
    end else begin
      // A new redirect restarts the chain; overlapping pulse trains merge.
      flush_q       <= redirect_take;
      flush_again_q <= flush_q;
      flush_final_q <= flush_again_q;

      if (redirect_take) begin
        skid_full <= 1'b0;
        instr_q   <= NOP_INSTR;
        valid_q   <= 1'b0;
        align_q   <= 1'b0;
        halt_pend <= 1'b0;
        if (rd && !bus.imem_done) begin
          // Request in flight: finish it on the old address, then jump.
          pending_pc <= bus.redirect_pc;
          state      <= DRAIN;
        end else begin
          pc    <= bus.redirect_pc;
          state <= RUN;
        end
      end else begin
        case (state)
          RUN: begin
            if (pc[0]) begin
              state   <= ALIGN;
              align_q <= 1'b1;
              instr_q <= NOP_INSTR;
              valid_q <= 1'b0;
            end else begin
              if (accept) pc <= pc_inc;
              if (bus.halt_i || halt_pend) begin
                if (rd && !bus.imem_done) begin
                  halt_pend <= 1'b1;
                end else begin
                  halt_pend <= 1'b0;
                  state     <= HALT;
                end
              end
            end
          end
          DRAIN: begin
            if (bus.imem_done) begin
              pc    <= pending_pc;
              state <= RUN;
            end
          end
          default: begin
          end
        endcase

        if (deliver_en) begin
          if (bus.stall_i) begin
            if (accept) begin
              skid_instr <= bus.imem_data;
              skid_pc2   <= pc_inc;
              skid_full  <= 1'b1;
            end
          end else if (skid_full) begin
            instr_q   <= skid_instr;
            pc2_q     <= skid_pc2;
            valid_q   <= 1'b1;
            skid_full <= 1'b0;
          end else if (accept) begin
            instr_q <= bus.imem_data;
            pc2_q   <= pc_inc;
            valid_q <= 1'b1;
          end else begin
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed scenarios plus a randomized stream
// checked against an instruction-stream scoreboard.
module tb_fetch_unit;
  localparam logic [15:0] NOP = 16'h0800;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;
  int   mem_lat;

  logic [15:0] mem_arr [logic [15:0]];
  logic [31:0] exp_q[$];

  fetch_unit_if bus();

  fetch_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: a few fixed words, a hash of the address everywhere else.
  function automatic logic [15:0] word_at(input logic [15:0] a);
    if (mem_arr.exists(a)) return mem_arr[a];
    return {a[7:0], a[15:8]} ^ 16'h3C5A;
  endfunction

  // Memory driver: answers a level request after mem_lat cycles (0 = random 1..4).
  initial begin : mem_model
    bit busy;
    int left;
    bit done_q;
    busy = 1'b0;
    left = 0;
    done_q = 1'b0;
    bus.imem_done  = 1'b0;
    bus.imem_data  = 16'h0000;
    bus.imem_stall = 1'b0;
    forever begin
      @(negedge clk);
      if (done_q) busy = 1'b0;
      if (bus.imem_rd === 1'b1) begin
        if (!busy) begin
          busy = 1'b1;
          left = (mem_lat == 0) ? int'($urandom_range(1, 4)) : mem_lat;
        end
        left = left - 1;
        bus.imem_done = (left == 0);
        bus.imem_data = bus.imem_done ? word_at(bus.imem_addr) : 16'($urandom);
      end else begin
        busy = 1'b0;
        bus.imem_done = 1'b0;
        bus.imem_data = 16'($urandom);
      end
      bus.imem_stall = busy && !bus.imem_done;
      done_q = bus.imem_done;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int lat);
    mem_lat = lat;
    bus.stall_i = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = 16'h0000;
    bus.halt_i = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    mem_lat = 4;
    bus.stall_i = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = 16'h0000; bus.halt_i = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    tests_run++; if (bus.instr !== NOP) begin tests_failed++; $display("FAIL reset_instr: got %h expected %h", bus.instr, NOP); end
    tests_run++; if (bus.valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b expected 0", bus.valid); end
    tests_run++; if (bus.pc_plus2 !== 16'h0000) begin tests_failed++; $display("FAIL reset_pc_plus2: got %h expected 0000", bus.pc_plus2); end
    tests_run++; if (bus.align_err_i !== 1'b0) begin tests_failed++; $display("FAIL reset_align: got %b expected 0", bus.align_err_i); end
    tests_run++; if ({bus.flush, bus.flush_again, bus.flush_final} !== 3'b000) begin tests_failed++; $display("FAIL reset_flush: got %b expected 000", {bus.flush, bus.flush_again, bus.flush_final}); end
    tests_run++; if (bus.imem_rd !== 1'b0) begin tests_failed++; $display("FAIL reset_rd: got %b expected 0", bus.imem_rd); end
    rst = 1'b0;
    #1;
    tests_run++; if (bus.imem_rd !== 1'b1 || bus.imem_addr !== 16'h0000) begin tests_failed++; $display("FAIL release_req: got rd=%b addr=%h expected rd=1 addr=0000", bus.imem_rd, bus.imem_addr); end
    tick();
    tick();
    // Reset in the middle of an open 4-cycle request.
    rst = 1'b1;
    #1;
    tests_run++; if (bus.imem_rd !== 1'b0) begin tests_failed++; $display("FAIL midreq_reset_rd: got %b expected 0", bus.imem_rd); end
    tick();
    tests_run++; if (bus.valid !== 1'b0) begin tests_failed++; $display("FAIL midreq_reset_valid: got %b expected 0", bus.valid); end
    rst = 1'b0;
    #1;
    tests_run++; if (bus.imem_rd !== 1'b1 || bus.imem_addr !== 16'h0000) begin tests_failed++; $display("FAIL midreq_restart: got rd=%b addr=%h expected rd=1 addr=0000", bus.imem_rd, bus.imem_addr); end
  endtask

  task automatic test_sequential_fetch();
    do_reset(1);
    tests_run++; if (bus.imem_addr !== 16'h0000 || bus.imem_rd !== 1'b1) begin tests_failed++; $display("FAIL seq_addr0: got rd=%b addr=%h expected rd=1 addr=0000", bus.imem_rd, bus.imem_addr); end
    tick();
    tests_run++; if (bus.imem_addr !== 16'h0002) begin tests_failed++; $display("FAIL seq_addr2: got %h expected 0002", bus.imem_addr); end
    tests_run++; if ({bus.valid, bus.instr, bus.pc_plus2} !== {1'b1, 16'hC001, 16'h0002}) begin tests_failed++; $display("FAIL seq_out0: got v=%b %h/%h expected v=1 c001/0002", bus.valid, bus.instr, bus.pc_plus2); end
    tick();
    tests_run++; if (bus.imem_addr !== 16'h0004) begin tests_failed++; $display("FAIL seq_addr4: got %h expected 0004", bus.imem_addr); end
    tests_run++; if ({bus.valid, bus.instr, bus.pc_plus2} !== {1'b1, 16'hC002, 16'h0004}) begin tests_failed++; $display("FAIL seq_out1: got v=%b %h/%h expected v=1 c002/0004", bus.valid, bus.instr, bus.pc_plus2); end
  endtask

  task automatic test_stall_skid();
    do_reset(1);
    tick();
    tick();
    bus.stall_i = 1'b1;
    tick();
    tests_run++; if (bus.imem_rd !== 1'b0) begin tests_failed++; $display("FAIL stall_rd_c1: got %b expected 0", bus.imem_rd); end
    tests_run++; if (bus.instr !== 16'hC002 || bus.valid !== 1'b1) begin tests_failed++; $display("FAIL stall_hold_c1: got v=%b %h expected v=1 c002", bus.valid, bus.instr); end
    tick();
    tests_run++; if (bus.imem_rd !== 1'b0 || bus.instr !== 16'hC002) begin tests_failed++; $display("FAIL stall_hold_c2: got rd=%b %h expected rd=0 c002", bus.imem_rd, bus.instr); end
    tick();
    bus.stall_i = 1'b0;
    tests_run++; if (bus.imem_rd !== 1'b0 || bus.instr !== 16'hC002) begin tests_failed++; $display("FAIL stall_fall: got rd=%b %h expected rd=0 c002", bus.imem_rd, bus.instr); end
    tick();
    tests_run++; if ({bus.valid, bus.instr, bus.pc_plus2} !== {1'b1, 16'hD0A0, 16'h0006}) begin tests_failed++; $display("FAIL skid_out: got v=%b %h/%h expected v=1 d0a0/0006", bus.valid, bus.instr, bus.pc_plus2); end
    tests_run++; if (bus.imem_rd !== 1'b1 || bus.imem_addr !== 16'h0006) begin tests_failed++; $display("FAIL skid_next_req: got rd=%b addr=%h expected rd=1 addr=0006", bus.imem_rd, bus.imem_addr); end
  endtask

  task automatic test_redirect_drain();
    do_reset(4);
    tick();
    bus.redirect = 1'b1;
    bus.redirect_pc = 16'h0100;
    tick();
    bus.redirect = 1'b0;
    tests_run++; if (bus.imem_rd !== 1'b1 || bus.imem_addr !== 16'h0000) begin tests_failed++; $display("FAIL drain_hold1: got rd=%b addr=%h expected rd=1 addr=0000", bus.imem_rd, bus.imem_addr); end
    tests_run++; if ({bus.flush, bus.flush_again, bus.flush_final} !== 3'b100) begin tests_failed++; $display("FAIL flush_n1: got %b expected 100", {bus.flush, bus.flush_again, bus.flush_final}); end
    tick();
    tests_run++; if (bus.imem_rd !== 1'b1 || bus.imem_addr !== 16'h0000) begin tests_failed++; $display("FAIL drain_hold2: got rd=%b addr=%h expected rd=1 addr=0000", bus.imem_rd, bus.imem_addr); end
    tests_run++; if ({bus.flush, bus.flush_again, bus.flush_final} !== 3'b010) begin tests_failed++; $display("FAIL flush_n2: got %b expected 010", {bus.flush, bus.flush_again, bus.flush_final}); end
    tick();
    tests_run++; if (bus.imem_rd !== 1'b1 || bus.imem_addr !== 16'h0100) begin tests_failed++; $display("FAIL drain_target: got rd=%b addr=%h expected rd=1 addr=0100", bus.imem_rd, bus.imem_addr); end
    tests_run++; if ({bus.flush, bus.flush_again, bus.flush_final} !== 3'b001) begin tests_failed++; $display("FAIL flush_n3: got %b expected 001", {bus.flush, bus.flush_again, bus.flush_final}); end
    tests_run++; if (bus.valid !== 1'b0 || bus.instr !== NOP) begin tests_failed++; $display("FAIL drain_discard: got v=%b %h expected v=0 %h", bus.valid, bus.instr, NOP); end
    tick();
    tests_run++; if ({bus.flush, bus.flush_again, bus.flush_final} !== 3'b000) begin tests_failed++; $display("FAIL flush_end: got %b expected 000", {bus.flush, bus.flush_again, bus.flush_final}); end
    tick();
    tick();
    tick();
    tests_run++; if ({bus.valid, bus.instr, bus.pc_plus2} !== {1'b1, word_at(16'h0100), 16'h0102}) begin tests_failed++; $display("FAIL redirect_fetch: got v=%b %h/%h expected v=1 %h/0102", bus.valid, bus.instr, bus.pc_plus2, word_at(16'h0100)); end
  endtask

  task automatic test_align();
    do_reset(1);
    tick();
    bus.redirect = 1'b1;
    bus.redirect_pc = 16'h0011;
    tick();
    bus.redirect = 1'b0;
    tests_run++; if (bus.imem_rd !== 1'b0) begin tests_failed++; $display("FAIL odd_no_req: got %b expected 0", bus.imem_rd); end
    tick();
    tests_run++; if (bus.align_err_i !== 1'b1 || bus.valid !== 1'b0) begin tests_failed++; $display("FAIL align_set: got err=%b v=%b expected err=1 v=0", bus.align_err_i, bus.valid); end
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++; if (bus.align_err_i !== 1'b1 || bus.imem_rd !== 1'b0) begin tests_failed++; $display("FAIL align_hold: got err=%b rd=%b expected err=1 rd=0", bus.align_err_i, bus.imem_rd); end
    end
    bus.redirect = 1'b1;
    bus.redirect_pc = 16'h0020;
    tick();
    bus.redirect = 1'b0;
    tests_run++; if (bus.align_err_i !== 1'b0) begin tests_failed++; $display("FAIL align_clear: got %b expected 0", bus.align_err_i); end
    tests_run++; if (bus.imem_rd !== 1'b1 || bus.imem_addr !== 16'h0020) begin tests_failed++; $display("FAIL align_refetch: got rd=%b addr=%h expected rd=1 addr=0020", bus.imem_rd, bus.imem_addr); end
    tick();
    tests_run++; if (bus.valid !== 1'b1 || bus.instr !== word_at(16'h0020)) begin tests_failed++; $display("FAIL align_refetch_out: got v=%b %h expected v=1 %h", bus.valid, bus.instr, word_at(16'h0020)); end
  endtask

  task automatic test_halt();
    do_reset(3);
    tick();
    bus.halt_i = 1'b1;
    tick();
    bus.halt_i = 1'b0;
    tests_run++; if (bus.imem_rd !== 1'b1 || bus.imem_addr !== 16'h0000) begin tests_failed++; $display("FAIL halt_finish_req: got rd=%b addr=%h expected rd=1 addr=0000", bus.imem_rd, bus.imem_addr); end
    tick();
    tests_run++; if (bus.valid !== 1'b1 || bus.instr !== 16'hC001) begin tests_failed++; $display("FAIL halt_deliver: got v=%b %h expected v=1 c001", bus.valid, bus.instr); end
    for (int i = 0; i < 6; i++) begin
      tests_run++; if (bus.imem_rd !== 1'b0) begin tests_failed++; $display("FAIL halt_rd: got %b expected 0", bus.imem_rd); end
      tick();
    end
    tests_run++; if (bus.valid !== 1'b0 || bus.instr !== NOP) begin tests_failed++; $display("FAIL halt_bubble: got v=%b %h expected v=0 %h", bus.valid, bus.instr, NOP); end
    do_reset(1);
    tests_run++; if (bus.imem_rd !== 1'b1 || bus.imem_addr !== 16'h0000) begin tests_failed++; $display("FAIL halt_reset: got rd=%b addr=%h expected rd=1 addr=0000", bus.imem_rd, bus.imem_addr); end
  endtask

  task automatic test_wrap();
    do_reset(1);
    bus.redirect = 1'b1;
    bus.redirect_pc = 16'hFFFE;
    tick();
    bus.redirect = 1'b0;
    tests_run++; if (bus.imem_addr !== 16'hFFFE) begin tests_failed++; $display("FAIL wrap_addr_fffe: got %h expected fffe", bus.imem_addr); end
    tick();
    tests_run++; if (bus.imem_addr !== 16'h0000) begin tests_failed++; $display("FAIL wrap_addr0: got %h expected 0000", bus.imem_addr); end
    tests_run++; if ({bus.valid, bus.instr, bus.pc_plus2} !== {1'b1, word_at(16'hFFFE), 16'h0000}) begin tests_failed++; $display("FAIL wrap_out: got v=%b %h/%h expected v=1 %h/0000", bus.valid, bus.instr, bus.pc_plus2, word_at(16'hFFFE)); end
  endtask

  // Random stalls, redirects and memory latency; every word decode takes must
  // be the next word of the program-order stream since the last redirect.
  task automatic test_random_stream();
    logic [15:0] next_fill;
    logic [31:0] exp;
    logic [2:0]  rhist;
    logic        prev_open;
    logic [15:0] prev_addr;
    int          consumed;
    do_reset(0);
    exp_q.delete();
    next_fill = 16'h0000;
    rhist = 3'b000;
    prev_open = 1'b0;
    prev_addr = 16'h0000;
    consumed = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bus.stall_i = ($urandom_range(0, 99) < 30);
      bus.redirect = ($urandom_range(0, 99) < 6);
      bus.redirect_pc = 16'($urandom) & 16'hFFFE;
      while (exp_q.size() < 8) begin
        exp_q.push_back({word_at(next_fill), next_fill + 16'd2});
        next_fill = next_fill + 16'd2;
      end
      @(negedge clk);
      #2;
      if (bus.valid === 1'b1 && bus.stall_i === 1'b0) begin
        exp = exp_q.pop_front();
        consumed++;
        tests_run++; if ({bus.instr, bus.pc_plus2} !== exp) begin tests_failed++; $display("FAIL rand_stream: cyc %0d got %h/%h expected %h/%h", cyc, bus.instr, bus.pc_plus2, exp[31:16], exp[15:0]); end
      end
      if (bus.valid === 1'b0) begin
        tests_run++; if (bus.instr !== NOP) begin tests_failed++; $display("FAIL rand_bubble: cyc %0d got %h expected %h", cyc, bus.instr, NOP); end
      end
      tests_run++; if (bus.align_err_i !== 1'b0) begin tests_failed++; $display("FAIL rand_align: cyc %0d got %b expected 0", cyc, bus.align_err_i); end
      tests_run++; if ({bus.flush, bus.flush_again, bus.flush_final} !== {rhist[0], rhist[1], rhist[2]}) begin tests_failed++; $display("FAIL rand_flush: cyc %0d got %b expected %b", cyc, {bus.flush, bus.flush_again, bus.flush_final}, {rhist[0], rhist[1], rhist[2]}); end
      if (prev_open) begin
        tests_run++; if (bus.imem_rd !== 1'b1 || bus.imem_addr !== prev_addr) begin tests_failed++; $display("FAIL rand_addr_stable: cyc %0d got rd=%b addr=%h expected rd=1 addr=%h", cyc, bus.imem_rd, bus.imem_addr, prev_addr); end
      end
      prev_open = (bus.imem_rd === 1'b1) && (bus.imem_done === 1'b0);
      prev_addr = bus.imem_addr;
      rhist = {rhist[1:0], bus.redirect};
      if (bus.redirect) begin
        exp_q.delete();
        next_fill = bus.redirect_pc;
      end
      @(posedge clk);
      #1;
    end
    bus.redirect = 1'b0;
    bus.stall_i = 1'b0;
    tests_run++; if (consumed < 100) begin tests_failed++; $display("FAIL rand_progress: got %0d words expected at least 100", consumed); end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    mem_lat = 1;
    rst = 1'b1;
    bus.stall_i = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = 16'h0000;
    bus.halt_i = 1'b0;
    mem_arr[16'h0000] = 16'hC001;
    mem_arr[16'h0002] = 16'hC002;
    mem_arr[16'h0004] = 16'hD0A0;
    test_reset();
    test_sequential_fetch();
    test_stall_skid();
    test_redirect_drain();
    test_align();
    test_halt();
    test_wrap();
    test_random_stream();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
